fetch_redirect_unit: RTL and testbench
======================================

Name: fetch_redirect_unit

Overview:
- Consumer end of the decode-stage branch comparison. It owns the fetch PC and the IF/ID pipeline register of the 5-stage MIPS pipeline.
- It takes the comparator's taken flag together with the D-stage instruction, and computes and registers the next fetch PC for branches, j/jal, jr/jalr and sequential flow.
- It honours the architectural delay slot (no flush) and the hazard unit's stall.

Parameters:
- RESET_PC, 32'h0000_3000, fetch PC after reset.
- NOP_INSTR, 32'h0000_0000, IR_D value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit stall; holds PC_F and the IF/ID register.
- br_cond  in  1  comparator decision for the instruction in IR_D (beq/bne/blez/bgtz/bltz/bgez), combinational, same cycle.
- rs_val_d  in  32  forwarded GPR[rs] for jr/jalr.
- instr_f  in  32  instruction-memory read data at pc_f (combinational IM).
- pc_f  out  32  current fetch PC, drives IM address.
- ir_d  out  32  registered D-stage instruction.
- pc_d  out  32  registered PC of ir_d.
- pc8_d  out  32  pc_d + 8, link value for jal/jalr.
- adel_d  out  1  registered flag: pc_d was not word-aligned.

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release on clk):
  - pc_f = RESET_PC, ir_d = NOP_INSTR, pc_d = RESET_PC, adel_d = 0.
  - pc8_d is combinational from pc_d, so it is RESET_PC+8 in reset.
- Decode of ir_d, combinational:
  - op = ir_d[31:26], funct = ir_d[5:0], rt = ir_d[20:16].
  - is_branch: op ∈ {000100, 000101, 000110, 000111}, or op = 000001 with rt ∈ {00000, 00001}.
  - is_j: op ∈ {000010, 000011}.
  - is_jr: op = 000000 and funct ∈ {001000, 001001}.
- Next PC, priority order:
  1. is_branch and br_cond: pc_d + 4 + (sign_ext(ir_d[15:0]) << 2).
  2. is_j: {pc_d[31:28], ir_d[25:0], 2'b00}.
  3. is_jr: rs_val_d.
  4. Otherwise: pc_f + 4.
  - A branch with br_cond = 0 falls through to sequential.
  - All adds are 32-bit modulo; wrap at 32'hFFFF_FFFC → 0 with no flag.
- Each rising edge with stall = 0:
  - pc_f ← npc.
  - ir_d ← instr_f, pc_d ← pc_f.
  - adel_d ← (pc_f[1:0] != 0).
- Each rising edge with stall = 1: pc_f, ir_d, pc_d and adel_d all hold.
  - A redirect that would occur this cycle is not lost: ir_d still holds the branch/jump, so it is re-evaluated next cycle with the updated br_cond/rs_val_d.
- Delay slot: when the redirect is taken, the instruction already fetched at pc_d+4 enters D on the same edge. There is never a flush.
- Latency: redirect decided in D takes effect on pc_f one edge later. Target instruction is in ir_d two edges after the branch entered D.
- Misaligned jr target: pc_f takes the value unmodified; the fault is reported via adel_d when that PC's instruction reaches D. The IM address is not masked.
- reset asserted mid-stall or mid-redirect: reset wins immediately.

Decomposition:
- Shared package / header: opcode constants OP_RTYPE, OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_J, OP_JAL; funct FN_JR, FN_JALR; rt codes RT_BLTZ, RT_BGEZ; RESET_PC default.
- One natural sub-module: npc_calc, the combinational next-PC mux/adders. The PC register and IF/ID register stay in the top.

Test Plan:
- Reset, then release with stall=0 and NOPs from IM → pc_f 3000, 3004, 3008 on successive edges; ir_d=0; pc8_d=pc_d+8.
- ir_d=beq with imm=16'h0004 at pc_d=3000, br_cond=1 → next pc_f=3014; the delay-slot instr from 3004 is in ir_d; instr at 3014 is in D one edge later. Same with br_cond=0 → pc_f=pc_f+4.
- ir_d=bltz imm=16'hFFFF at pc_d=3010, br_cond=1 → pc_f=3010 (pc_d+4-4).
- ir_d=jal index 26'h0000C10 at pc_d=3008 → pc_f=3040, pc8_d=3010; ir_d=jr with rs_val_d=0000_3100 → pc_f=3100.
- stall=1 for 2 cycles while ir_d=bne and br_cond toggles 0→1 → pc_f/ir_d frozen; on the first unstalled edge pc_f=branch target.
- jr with rs_val_d=0000_3002 → pc_f=3002; one edge later adel_d=1 and pc_d=3002. Assert reset mid-sequence → pc_f=3000 and adel_d=0 asynchronously.

Source files
------------

// File: rtl/fetch_redirect_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_redirect_unit_pkg
//   Shared MIPS encodings and helpers for the fetch/redirect block.
//   Contents:
//     - opcode, funct and REGIMM rt constants used by the D-stage decode
//     - default reset PC and NOP word
//     - npc_sel_e    : which source feeds the next fetch PC
//     - instr_class_t: control-flow class of the D-stage instruction
//     - classify()   : maps op/rt/funct fields to an instr_class_t
// -----------------------------------------------------------------------------
package fetch_redirect_unit_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [5:0] FN_JR     = 6'b001000;
  localparam logic [5:0] FN_JALR   = 6'b001001;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  // Source of the next fetch PC, listed from lowest to highest priority.
  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_JREG   = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_BRANCH = 2'd3
  } npc_sel_e;

  typedef struct packed {
    logic is_branch;  // conditional branch; taken only when br_cond is set
    logic is_j;       // j / jal, pseudo-direct target
    logic is_jr;      // jr / jalr, register target
  } instr_class_t;

  function automatic instr_class_t classify(input logic [5:0] op,
                                            input logic [4:0] rt,
                                            input logic [5:0] funct);
    instr_class_t c;
    c.is_branch = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) ||
                  (op == OP_BGTZ) ||
                  ((op == OP_REGIMM) && ((rt == RT_BLTZ) || (rt == RT_BGEZ)));
    c.is_j      = (op == OP_J) || (op == OP_JAL);
    c.is_jr     = (op == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR));
    return c;
  endfunction

endpackage

// File: rtl/fetch_redirect_unit_npc_calc.sv
// -----------------------------------------------------------------------------
// fetch_redirect_unit_npc_calc
//   Combinational next-fetch-PC selection for the D-stage instruction.
//   Ports:
//     ir_d_i    in  32  D-stage instruction
//     pc_d_i    in  32  PC of ir_d_i
//     pc_f_i    in  32  current fetch PC
//     br_cond_i in  1   comparator decision for a conditional branch in D
//     rs_val_i  in  32  forwarded GPR[rs] (jr/jalr target)
//     npc_o     out 32  next fetch PC
//   Priority: taken branch > j/jal > jr/jalr > sequential (pc_f + 4).
//   All arithmetic is 32-bit modulo; wrap-around is silent.
// -----------------------------------------------------------------------------
module fetch_redirect_unit_npc_calc
  import fetch_redirect_unit_pkg::*;
(
  input  logic [31:0] ir_d_i,
  input  logic [31:0] pc_d_i,
  input  logic [31:0] pc_f_i,
  input  logic        br_cond_i,
  input  logic [31:0] rs_val_i,
  output logic [31:0] npc_o
);

  instr_class_t cls;
  npc_sel_e     sel;
  logic [31:0]  br_offset;
  logic [31:0]  br_target;
  logic [31:0]  j_target;
  logic [31:0]  seq_pc;

  always_comb begin
    // NOTE: every variable gets a value before any branch so no path can
    // leave one unassigned and infer a latch.
    sel       = NPC_SEQ;
    npc_o     = '0;

    cls       = classify(ir_d_i[31:26], ir_d_i[20:16], ir_d_i[5:0]);
    // Branch offset is relative to the delay-slot address (pc_d + 4).
    br_offset = {{14{ir_d_i[15]}}, ir_d_i[15:0], 2'b00};
    br_target = pc_d_i + 32'd4 + br_offset;
    // Pseudo-direct jump keeps the 256 MB region of the jump itself.
    j_target  = {pc_d_i[31:28], ir_d_i[25:0], 2'b00};
    seq_pc    = pc_f_i + 32'd4;

    if (cls.is_branch && br_cond_i) sel = NPC_BRANCH;
    else if (cls.is_j)              sel = NPC_JUMP;
    else if (cls.is_jr)             sel = NPC_JREG;

    unique case (sel)
      NPC_BRANCH: npc_o = br_target;
      NPC_JUMP:   npc_o = j_target;
      NPC_JREG:   npc_o = rs_val_i;   // not masked; misalignment surfaces as adel_d
      default:    npc_o = seq_pc;
    endcase
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// -----------------------------------------------------------------------------
// fetch_redirect_unit
//   Owns the fetch PC and the IF/ID pipeline register of a 5-stage MIPS
//   pipeline. Redirects for branches (delay slot honoured, never flushed),
//   j/jal and jr/jalr are decided in D and land on pc_f one edge later.
//   Ports:
//     clk      in  1   system clock, rising edge
//     reset    in  1   asynchronous active-low reset
//     stall    in  1   hazard stall: holds pc_f and the IF/ID register
//     br_cond  in  1   comparator decision for the branch in ir_d
//     rs_val_d in  32  forwarded GPR[rs] for jr/jalr
//     instr_f  in  32  instruction-memory data at pc_f
//     pc_f     out 32  fetch PC (IM address)
//     ir_d     out 32  D-stage instruction
//     pc_d     out 32  PC of ir_d
//     pc8_d    out 32  pc_d + 8, link value for jal/jalr
//     adel_d   out 1   pc_d was not word-aligned
// -----------------------------------------------------------------------------
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_cond,
  input  logic [31:0] rs_val_d,
  input  logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] ir_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        adel_d
);

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] ir_d_q, ir_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic        adel_d_q, adel_d_d;
  logic [31:0] npc;

  fetch_redirect_unit_npc_calc u_npc_calc (
    .ir_d_i    (ir_d_q),
    .pc_d_i    (pc_d_q),
    .pc_f_i    (pc_f_q),
    .br_cond_i (br_cond),
    .rs_val_i  (rs_val_d),
    .npc_o     (npc)
  );

  // A stalled redirect is not lost: ir_d keeps the control-flow instruction,
  // so it is re-decided next cycle with the then-current br_cond/rs_val_d.
  always_comb begin
    pc_f_d   = pc_f_q;
    ir_d_d   = ir_d_q;
    pc_d_d   = pc_d_q;
    adel_d_d = adel_d_q;
    if (!stall) begin
      pc_f_d   = npc;
      ir_d_d   = instr_f;          // delay-slot instruction enters D, no flush
      pc_d_d   = pc_f_q;
      adel_d_d = |pc_f_q[1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f_q   <= RESET_PC;
      ir_d_q   <= NOP_INSTR;
      pc_d_q   <= RESET_PC;
      adel_d_q <= 1'b0;
    end else begin
      pc_f_q   <= pc_f_d;
      ir_d_q   <= ir_d_d;
      pc_d_q   <= pc_d_d;
      adel_d_q <= adel_d_d;
    end
  end

  assign pc_f   = pc_f_q;
  assign ir_d   = ir_d_q;
  assign pc_d   = pc_d_q;
  assign pc8_d  = pc_d_q + 32'd8;
  assign adel_d = adel_d_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_redirect_unit
//   Directed scenarios against a small instruction memory. A behavioural model
//   (instruction-level next-PC rules) is compared with the DUT on every falling
//   edge; hand-computed literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_fetch_redirect_unit;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        stall    = 1'b0;
  logic        br_cond  = 1'b0;
  logic [31:0] rs_val_d = 32'h0;
  logic [31:0] instr_f;
  logic [31:0] pc_f, ir_d, pc_d, pc8_d;
  logic        adel_d;

  // Instruction memory covering 0x3000..0x33FF, zero elsewhere. Word lookup
  // ignores pc[1:0], so a misaligned PC reads the enclosing word.
  logic [31:0] imem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb instr_f = (pc_f[31:10] == 22'h00000C) ? imem[pc_f[9:2]] : 32'h0;

  fetch_redirect_unit dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .br_cond  (br_cond),
    .rs_val_d (rs_val_d),
    .instr_f  (instr_f),
    .pc_f     (pc_f),
    .ir_d     (ir_d),
    .pc_d     (pc_d),
    .pc8_d    (pc8_d),
    .adel_d   (adel_d)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] im_read(input logic [31:0] a);
    if (a[31:10] == 22'h00000C) return imem[a[9:2]];
    return 32'h0;
  endfunction

  function automatic logic [31:0] model_npc(input logic [31:0] ir, input logic [31:0] pcd,
                                            input logic [31:0] pcf, input logic br,
                                            input logic [31:0] rs);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    int         off;
    bit         cond_br;
    op      = ir[31:26];
    fn      = ir[5:0];
    rt      = ir[20:16];
    off     = int'($signed(ir[15:0]));
    cond_br = (op >= 6'd4 && op <= 6'd7) || (op == 6'd1 && rt < 5'd2);
    if (cond_br && br)                          return pcd + 32'd4 + 32'(off * 4);
    if (op == 6'd2 || op == 6'd3)               return {pcd[31:28], ir[25:0], 2'b00};
    if (op == 6'd0 && (fn == 6'd8 || fn == 6'd9)) return rs;
    return pcf + 32'd4;
  endfunction

  logic [31:0] m_pc_f, m_ir, m_pc_d;
  logic        m_adel;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc_f <= 32'h0000_3000;
      m_ir   <= 32'h0;
      m_pc_d <= 32'h0000_3000;
      m_adel <= 1'b0;
    end else if (!stall) begin
      m_pc_f <= model_npc(m_ir, m_pc_d, m_pc_f, br_cond, rs_val_d);
      m_ir   <= im_read(m_pc_f);
      m_pc_d <= m_pc_f;
      m_adel <= (m_pc_f[1:0] != 2'b00);
    end
  end

  always @(negedge clk) begin
    check("model pc_f",   pc_f,           m_pc_f);
    check("model ir_d",   ir_d,           m_ir);
    check("model pc_d",   pc_d,           m_pc_d);
    check("model pc8_d",  pc8_d,          m_pc_d + 32'd8);
    check("model adel_d", {31'h0, adel_d}, {31'h0, m_adel});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    reset    = 1'b0;
    stall    = 1'b0;
    br_cond  = 1'b0;
    rs_val_d = 32'h0;
    foreach (imem[i]) imem[i] = 32'h0;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    imem[a[9:2]] = w;
  endtask

  task automatic release_reset();
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Sequential flow with NOPs
    start();
    tick();
    check("rst pc_f",  pc_f,  32'h0000_3000);
    check("rst ir_d",  ir_d,  32'h0);
    check("rst pc_d",  pc_d,  32'h0000_3000);
    check("rst pc8_d", pc8_d, 32'h0000_3008);
    check("rst adel",  {31'h0, adel_d}, 32'h0);
    release_reset();
    tick();
    check("seq pc_f 1", pc_f, 32'h0000_3004);
    check("seq pc_d 1", pc_d, 32'h0000_3000);
    tick();
    check("seq pc_f 2",  pc_f,  32'h0000_3008);
    check("seq pc8_d 2", pc8_d, 32'h0000_300C);
    check("seq ir_d 2",  ir_d,  32'h0);

    // beq taken, imm 4 at 0x3000 -> 0x3014, delay slot from 0x3004
    start();
    put(32'h3000, 32'h1000_0004);
    put(32'h3004, 32'h2401_0001);
    put(32'h3014, 32'h2402_0002);
    br_cond = 1'b1;
    release_reset();
    tick();
    check("beq in D",    ir_d, 32'h1000_0004);
    tick();
    check("beq target",  pc_f, 32'h0000_3014);
    check("beq delay",   ir_d, 32'h2401_0001);
    tick();
    check("beq tgt in D", ir_d, 32'h2402_0002);
    check("beq tgt pc_d", pc_d, 32'h0000_3014);

    // beq not taken falls through
    start();
    put(32'h3000, 32'h1000_0004);
    put(32'h3004, 32'h2401_0001);
    release_reset();
    tick();
    tick();
    check("beq nt pc_f", pc_f, 32'h0000_3008);
    check("beq nt ir_d", ir_d, 32'h2401_0001);

    // bltz imm -1 at 0x3010 -> back to 0x3010
    start();
    put(32'h3010, 32'h0400_FFFF);
    br_cond = 1'b1;
    release_reset();
    repeat (5) tick();
    check("bltz in D", pc_d, 32'h0000_3010);
    tick();
    check("bltz target", pc_f, 32'h0000_3010);
    check("bltz delay pc_d", pc_d, 32'h0000_3014);
    tick();
    check("bltz again", ir_d, 32'h0400_FFFF);

    // jal at 0x3008 -> 0x3040, then jr -> 0x3100
    start();
    put(32'h3008, 32'h0C00_0C10);
    put(32'h3040, 32'h0020_0008);
    rs_val_d = 32'h0000_3100;
    release_reset();
    repeat (3) tick();
    check("jal in D",  ir_d,  32'h0C00_0C10);
    check("jal link",  pc8_d, 32'h0000_3010);
    tick();
    check("jal target", pc_f, 32'h0000_3040);
    tick();
    check("jr in D",   ir_d,  32'h0020_0008);
    tick();
    check("jr target", pc_f,  32'h0000_3100);

    // bne held under stall while br_cond rises
    start();
    put(32'h3000, 32'h1420_0008);
    release_reset();
    tick();
    stall = 1'b1;
    tick();
    check("stall1 pc_f", pc_f, 32'h0000_3004);
    check("stall1 ir_d", ir_d, 32'h1420_0008);
    br_cond = 1'b1;
    tick();
    check("stall2 pc_f", pc_f, 32'h0000_3004);
    check("stall2 pc_d", pc_d, 32'h0000_3000);
    stall = 1'b0;
    tick();
    check("bne target", pc_f, 32'h0000_3024);
    check("bne delay pc_d", pc_d, 32'h0000_3004);

    // misaligned jr target, then async reset mid-sequence
    start();
    put(32'h3000, 32'h0020_0008);
    rs_val_d = 32'h0000_3002;
    release_reset();
    tick();
    tick();
    check("jr odd pc_f", pc_f, 32'h0000_3002);
    check("jr odd adel pre", {31'h0, adel_d}, 32'h0);
    tick();
    check("jr odd pc_d", pc_d, 32'h0000_3002);
    check("jr odd adel", {31'h0, adel_d}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("async rst pc_f", pc_f, 32'h0000_3000);
    check("async rst adel", {31'h0, adel_d}, 32'h0);

    // wrap from 0xFFFF_FFFC to 0
    start();
    put(32'h3000, 32'h0020_0008);
    rs_val_d = 32'hFFFF_FFFC;
    release_reset();
    tick();
    tick();
    check("wrap top", pc_f, 32'hFFFF_FFFC);
    tick();
    check("wrap pc_f",  pc_f,  32'h0000_0000);
    check("wrap pc8_d", pc8_d, 32'h0000_0004);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
